// File: rtl/cache_miss_ctrl_pkg.sv
// Shared LC-3b cache types: word/line types, address split widths and miss FSM states.
package lc3b_types;

  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned TAG_W    = 9;
  localparam int unsigned LINE_W   = 128;

  typedef logic [15:0]       lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_line;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB    = 3'd1,
    S_FETCH = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } miss_state_t;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Physical memory bus between the miss controller (master) and memory (slave).
interface cache_miss_ctrl_if #(
  parameter int unsigned width = 128
);
  logic [15:0]      pmem_address;
  logic             pmem_read;
  logic             pmem_write;
  logic [width-1:0] pmem_wdata;
  logic [width-1:0] pmem_rdata;
  logic             pmem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_miss_ctrl_miss_line_latch.sv
// Holds the miss context captured at acceptance plus the fetched fill line.
module miss_line_latch
  import lc3b_types::*;
#(
  parameter int unsigned width = LINE_W,
  parameter int unsigned tag_w = TAG_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             capture,
  input  logic [15:0]      miss_addr,
  input  logic [1:0]       victim_way,
  input  logic [tag_w-1:0] victim_tag,
  input  logic [width-1:0] victim_data,
  input  logic             rdata_we,
  input  logic [width-1:0] pmem_rdata,
  output logic [11:0]      line_q,
  output logic [1:0]       way_q,
  output logic [tag_w-1:0] tag_q,
  output logic [width-1:0] vdata_q,
  output logic [width-1:0] rdata_q
);

  // Byte offset never reaches memory: all transfers are line-aligned.
  logic unused_offset;
  assign unused_offset = ^miss_addr[3:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      line_q  <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (capture) begin
        line_q  <= miss_addr[15:4];
        way_q   <= victim_way;
        tag_q   <= victim_tag;
        vdata_q <= victim_data;
      end
      if (rdata_we) begin
        rdata_q <= pmem_rdata;
      end
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: optional writeback, line fetch, array fill, done pulse.
// Define CACHE_MISS_PERF_CNT_EN to add the miss_count/wb_count performance counters.
module cache_miss_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned width = LINE_W,
  parameter int unsigned tag_w = TAG_W
) (
  input  logic                clk,
  input  logic                reset_n,
  cache_miss_ctrl_if.master   pmem,
  input  logic                miss_req,
  input  logic [15:0]         miss_addr,
  input  logic [1:0]          victim_way,
  input  logic                victim_valid,
  input  logic                victim_dirty,
  input  logic [tag_w-1:0]    victim_tag,
  input  logic [width-1:0]    victim_data,
  output logic                fill_we,
  output logic [1:0]          fill_way,
  output logic [tag_w-1:0]    fill_tag,
  output logic [width-1:0]    fill_data,
  output logic                miss_done
`ifdef CACHE_MISS_PERF_CNT_EN
  ,
  output logic [15:0]         miss_count,
  output logic [15:0]         wb_count
`endif
);

  miss_state_t      state, state_nx;
  logic             capture;
  logic             rdata_we;
  logic [11:0]      line_q;
  logic [1:0]       way_q;
  logic [tag_w-1:0] tag_q;
  logic [width-1:0] vdata_q;
  logic [width-1:0] rdata_q;

  assign capture  = (state == S_IDLE) && miss_req;
  assign rdata_we = (state == S_FETCH) && pmem.pmem_resp;

  miss_line_latch #(
    .width(width),
    .tag_w(tag_w)
  ) u_latch (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture    (capture),
    .miss_addr  (miss_addr),
    .victim_way (victim_way),
    .victim_tag (victim_tag),
    .victim_data(victim_data),
    .rdata_we   (rdata_we),
    .pmem_rdata (pmem.pmem_rdata),
    .line_q     (line_q),
    .way_q      (way_q),
    .tag_q      (tag_q),
    .vdata_q    (vdata_q),
    .rdata_q    (rdata_q)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (miss_req) state_nx = (victim_valid && victim_dirty) ? S_WB : S_FETCH;
      S_WB:    if (pmem.pmem_resp) state_nx = S_FETCH;
      S_FETCH: if (pmem.pmem_resp) state_nx = S_FILL;
      S_FILL:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Outputs decode only the state register and the captured context, so they
  // stay steady for the whole wait and read as zero outside their own state.
  always_comb begin
    pmem.pmem_read    = (state == S_FETCH);
    pmem.pmem_write   = (state == S_WB);
    pmem.pmem_address = '0;
    pmem.pmem_wdata   = '0;
    if (state == S_WB) begin
      pmem.pmem_address = {tag_q, line_q[2:0], 4'b0000};
      pmem.pmem_wdata   = vdata_q;
    end else if (state == S_FETCH) begin
      pmem.pmem_address = {line_q, 4'b0000};
    end
  end

  always_comb begin
    fill_we   = (state == S_FILL);
    fill_way  = '0;
    fill_tag  = '0;
    fill_data = '0;
    if (state == S_FILL) begin
      fill_way  = way_q;
      fill_tag  = line_q[11:3];
      fill_data = rdata_q;
    end
    miss_done = (state == S_DONE);
  end

`ifdef CACHE_MISS_PERF_CNT_EN
  // Every accepted miss eventually fetches, so count at acceptance rather
  // than at the FETCH entry (dirty misses reach FETCH via WB).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      miss_count <= '0;
      wb_count   <= '0;
    end else if (capture) begin
      if (miss_count != '1) miss_count <= miss_count + 16'd1;
      if (victim_valid && victim_dirty && (wb_count != '1)) wb_count <= wb_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: vector table driven through a bus scoreboard.
module tb_cache_miss_ctrl;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         miss_req;
  logic [15:0]  miss_addr;
  logic [1:0]   victim_way;
  logic         victim_valid;
  logic         victim_dirty;
  logic [8:0]   victim_tag;
  logic [127:0] victim_data;
  logic         fill_we;
  logic [1:0]   fill_way;
  logic [8:0]   fill_tag;
  logic [127:0] fill_data;
  logic         miss_done;
`ifdef CACHE_MISS_PERF_CNT_EN
  logic [15:0]  miss_count;
  logic [15:0]  wb_count;
`endif

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.width(128)) pmem_if ();

  cache_miss_ctrl #(
    .width(128),
    .tag_w(9)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pmem        (pmem_if.master),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .victim_way  (victim_way),
    .victim_valid(victim_valid),
    .victim_dirty(victim_dirty),
    .victim_tag  (victim_tag),
    .victim_data (victim_data),
    .fill_we     (fill_we),
    .fill_way    (fill_way),
    .fill_tag    (fill_tag),
    .fill_data   (fill_data),
    .miss_done   (miss_done)
`ifdef CACHE_MISS_PERF_CNT_EN
    ,
    .miss_count  (miss_count),
    .wb_count    (wb_count)
`endif
  );

  localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_FILL = 2'd2, EV_DONE = 2'd3;

  typedef struct {
    logic [1:0]   kind;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [1:0]   way;
    logic [8:0]   tag;
  } ev_t;

  typedef struct {
    logic [15:0]  addr;
    logic [1:0]   way;
    logic         valid;
    logic         dirty;
    logic [8:0]   vtag;
    logic [127:0] vdata;
    logic [127:0] rdata;
    int           wb_dly;
    int           rd_dly;
    bit           drop;
    bit           exp_wb;
    logic [15:0]  exp_wb_addr;
    logic [15:0]  exp_rd_addr;
    logic [8:0]   exp_tag;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[6];

  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  logic done_seen;
  logic mon_en;
  logic prev_wr, prev_rd, prev_fill;
  logic [15:0] prev_addr;
  ev_t  mon_e;
  bit   mon_ok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic pop_ev(output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: '0};
    if (exp_q.size() == 0) begin
      check("unexpected_event", 128'd1, 128'd0);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Bus monitor: each observed transaction is matched against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pmem_if.pmem_read || pmem_if.pmem_write)
        check("rw_exclusive", 128'(pmem_if.pmem_read & pmem_if.pmem_write), 128'd0);
      if (pmem_if.pmem_write && !prev_wr) begin
        pop_ev(mon_e, mon_ok);
        if (mon_ok) begin
          check("wr_kind", 128'(EV_WR), 128'(mon_e.kind));
          check("wr_addr", 128'(pmem_if.pmem_address), 128'(mon_e.addr));
          check("wr_data", pmem_if.pmem_wdata, mon_e.data);
        end
      end else if (pmem_if.pmem_write) begin
        check("wr_addr_hold", 128'(pmem_if.pmem_address), 128'(prev_addr));
      end
      if (pmem_if.pmem_read && !prev_rd) begin
        pop_ev(mon_e, mon_ok);
        if (mon_ok) begin
          check("rd_kind", 128'(EV_RD), 128'(mon_e.kind));
          check("rd_addr", 128'(pmem_if.pmem_address), 128'(mon_e.addr));
        end
      end else if (pmem_if.pmem_read) begin
        check("rd_addr_hold", 128'(pmem_if.pmem_address), 128'(prev_addr));
      end
      if (fill_we) begin
        check("fill_one_cycle", 128'(prev_fill), 128'd0);
        pop_ev(mon_e, mon_ok);
        if (mon_ok) begin
          check("fill_kind", 128'(EV_FILL), 128'(mon_e.kind));
          check("fill_way", 128'(fill_way), 128'(mon_e.way));
          check("fill_tag", 128'(fill_tag), 128'(mon_e.tag));
          check("fill_data", fill_data, mon_e.data);
        end
      end
      if (miss_done) begin
        pop_ev(mon_e, mon_ok);
        if (mon_ok) check("done_kind", 128'(EV_DONE), 128'(mon_e.kind));
        done_seen <= 1'b1;
        done_cyc  <= cyc;
      end
    end
    prev_wr   <= pmem_if.pmem_write;
    prev_rd   <= pmem_if.pmem_read;
    prev_fill <= fill_we;
    prev_addr <= pmem_if.pmem_address;
  end

  task automatic check_quiet(input string pfx);
    check({pfx, "_read"},  128'(pmem_if.pmem_read), 128'd0);
    check({pfx, "_write"}, 128'(pmem_if.pmem_write), 128'd0);
    check({pfx, "_fill_we"}, 128'(fill_we), 128'd0);
    check({pfx, "_done"},  128'(miss_done), 128'd0);
    check({pfx, "_addr"},  128'(pmem_if.pmem_address), 128'd0);
    check({pfx, "_wdata"}, pmem_if.pmem_wdata, 128'd0);
    check({pfx, "_fill_way"}, 128'(fill_way), 128'd0);
    check({pfx, "_fill_tag"}, 128'(fill_tag), 128'd0);
    check({pfx, "_fill_data"}, fill_data, 128'd0);
  endtask

  // Called and returns at posedge+#1.
  task automatic respond(input int dly, input logic [127:0] rdata);
    repeat (dly) begin
      @(posedge clk); #1;
    end
    pmem_if.pmem_rdata = rdata;
    pmem_if.pmem_resp  = 1'b1;
    @(posedge clk); #1;
    pmem_if.pmem_resp  = 1'b0;
    pmem_if.pmem_rdata = junk();
  endtask

  task automatic do_miss(input vec_t v);
    int start;
    int exp_lat;
    done_seen = 1'b0;
    if (v.exp_wb) exp_q.push_back('{EV_WR, v.exp_wb_addr, v.vdata, 2'd0, 9'd0});
    exp_q.push_back('{EV_RD, v.exp_rd_addr, 128'd0, 2'd0, 9'd0});
    exp_q.push_back('{EV_FILL, 16'd0, v.rdata, v.way, v.exp_tag});
    exp_q.push_back('{EV_DONE, 16'd0, 128'd0, 2'd0, 9'd0});
    exp_lat = v.exp_wb ? (v.wb_dly + v.rd_dly + 4) : (v.rd_dly + 3);
    miss_addr    = v.addr;
    victim_way   = v.way;
    victim_valid = v.valid;
    victim_dirty = v.dirty;
    victim_tag   = v.vtag;
    victim_data  = v.vdata;
    miss_req     = 1'b1;
    start        = cyc;
    @(posedge clk); #1;
    miss_addr    = 16'($urandom);
    victim_way   = 2'($urandom);
    victim_tag   = 9'($urandom);
    victim_data  = junk();
    victim_valid = 1'($urandom);
    victim_dirty = 1'($urandom);
    if (v.exp_wb) respond(v.wb_dly, junk());
    if (v.drop) miss_req = 1'b0;
    respond(v.rd_dly, v.rdata);
    for (int i = 0; i < 20 && !done_seen; i++) @(posedge clk);
    #1;
    miss_req = 1'b0;
    check("done_seen", 128'(done_seen), 128'd1);
    if (done_seen) check("latency", 128'(done_cyc - start), 128'(exp_lat));
  endtask

  initial begin
    reset_n = 1'b0;
    miss_req = 1'b0;
    miss_addr = '0;
    victim_way = '0;
    victim_valid = 1'b0;
    victim_dirty = 1'b0;
    victim_tag = '0;
    victim_data = '0;
    pmem_if.pmem_rdata = '0;
    pmem_if.pmem_resp = 1'b0;
    mon_en = 1'b0;
    done_seen = 1'b0;

    vecs[0] = '{16'h1234, 2'd2, 1'b0, 1'b0, 9'h055, {4{32'hDEAD_0000}}, {4{32'h1111_2222}},
                0, 3, 1'b0, 1'b0, 16'h0000, 16'h1230, 9'h024};
    vecs[1] = '{16'h4A37, 2'd1, 1'b1, 1'b1, 9'h1FF, {4{32'hCAFE_F00D}}, {4{32'h3333_4444}},
                2, 1, 1'b0, 1'b1, 16'hFFB0, 16'h4A30, 9'h094};
    vecs[2] = '{16'hBEEF, 2'd3, 1'b1, 1'b0, 9'h0F0, {4{32'h0BAD_BEEF}}, {4{32'h5555_6666}},
                0, 0, 1'b0, 1'b0, 16'h0000, 16'hBEE0, 9'h17D};
    vecs[3] = '{16'h0070, 2'd0, 1'b1, 1'b1, 9'h001, {4{32'h7777_8888}}, {4{32'h9999_AAAA}},
                0, 0, 1'b0, 1'b1, 16'h00F0, 16'h0070, 9'h000};
    vecs[4] = '{16'hFFFF, 2'd1, 1'b0, 1'b1, 9'h123, {4{32'hBBBB_CCCC}}, {4{32'hDDDD_EEEE}},
                0, 2, 1'b0, 1'b0, 16'h0000, 16'hFFF0, 9'h1FF};
    vecs[5] = '{16'h8000, 2'd2, 1'b0, 1'b0, 9'h0AA, {4{32'h0123_4567}}, {4{32'h89AB_CDEF}},
                0, 4, 1'b1, 1'b0, 16'h0000, 16'h8000, 9'h100};

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk); #1;

`ifdef CACHE_MISS_PERF_CNT_EN
    check("miss_count_reset", 128'(miss_count), 128'd0);
    check("wb_count_reset", 128'(wb_count), 128'd0);
    do_miss(vecs[0]);
    do_miss(vecs[1]);
    do_miss(vecs[2]);
    check("miss_count_3", 128'(miss_count), 128'd3);
    check("wb_count_1", 128'(wb_count), 128'd1);
    force dut.miss_count = 16'hFFFE;
    force dut.wb_count   = 16'hFFFE;
    #1;
    release dut.miss_count;
    release dut.wb_count;
    do_miss(vecs[1]);
    do_miss(vecs[3]);
    check("miss_count_sat", 128'(miss_count), 128'hFFFF);
    check("wb_count_sat", 128'(wb_count), 128'hFFFF);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("miss_count_clr", 128'(miss_count), 128'd0);
    check("wb_count_clr", 128'(wb_count), 128'd0);
`endif

    // A response with no request outstanding must not start anything.
    pmem_if.pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_if.pmem_resp = 1'b0;
    @(posedge clk); #1;
    check_quiet("stray_resp");

    for (int i = 0; i < 6; i++) begin
      do_miss(vecs[i]);
      @(posedge clk); #1;
    end

    // Reset while the writeback is outstanding drops the whole transaction.
    done_seen = 1'b0;
    exp_q.push_back('{EV_WR, 16'h5550, {4{32'h4242_4242}}, 2'd0, 9'd0});
    miss_addr    = 16'h5A50;
    victim_way   = 2'd3;
    victim_valid = 1'b1;
    victim_dirty = 1'b1;
    victim_tag   = 9'h0AA;
    victim_data  = {4{32'h4242_4242}};
    miss_req     = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wb_pending", 128'(pmem_if.pmem_write), 128'd1);
    reset_n  = 1'b0;
    miss_req = 1'b0;
    @(posedge clk); #1;
    check_quiet("reset_in_wb");
    reset_n = 1'b1;
    @(posedge clk); #1;
    pmem_if.pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_if.pmem_resp = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("reset_no_done", 128'(done_seen), 128'd0);
    check("reset_queue_empty", 128'(exp_q.size()), 128'd0);
    do_miss(vecs[0]);

    repeat (2) @(posedge clk);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
